// File: rtl/tx_frame_ser.sv
// Serialises one gPTP message per handshake to the MAC, MSB byte first, and reports the
// egress timestamp (RTC at first-byte acceptance plus fixed latency) as a one-cycle pulse.
module tx_frame_ser #(
  parameter int unsigned MSG_BYTES     = 44,
  parameter logic [31:0] EGRESS_LAT_NS = 32'd0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   gptp_ts_vaild,
  output logic                   gptp_ts_ready,
  input  logic [MSG_BYTES*8-1:0] gptp_ts_data,
  output logic                   gptp_ts_rv_vaild,
  output logic [79:0]            gptp_ts_rv_data,
  input  logic [79:0]            rtc_time,
  output logic [7:0]             mac_tx_data,
  output logic                   mac_tx_vaild,
  output logic                   mac_tx_last,
  input  logic                   mac_tx_ready
);

  localparam int          W          = MSG_BYTES * 8;
  localparam int          CW         = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MSG_BYTES - 1);
  localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

  typedef enum logic [1:0] {IDLE, SEND, REPORT} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_shreg;
  logic [CW-1:0] r_cnt;
  logic [79:0]   r_ts;
  logic [79:0]   r_rv_data;
  logic          r_ready;

  logic          w_in_hs;
  logic          w_byte_acc;
  logic          w_last;
  logic [31:0]   w_ns_sum;
  logic          w_ns_wrap;
  logic [79:0]   w_ts_corr;

  assign w_in_hs    = gptp_ts_vaild & r_ready & (r_state == IDLE);
  assign w_byte_acc = (r_state == SEND) & mac_tx_ready;
  assign w_last     = (r_cnt == LAST_CNT);

  // Both addends are below 1e9, so the sum fits in 32 bits and wraps at most once.
  assign w_ns_sum  = rtc_time[31:0] + EGRESS_LAT_NS;
  assign w_ns_wrap = (w_ns_sum >= NS_PER_SEC);
  assign w_ts_corr = w_ns_wrap ? {rtc_time[79:32] + 48'd1, w_ns_sum - NS_PER_SEC}
                               : {rtc_time[79:32], w_ns_sum};

  assign gptp_ts_ready   = r_ready;
  assign gptp_ts_rv_data = r_rv_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next           = r_state;
    mac_tx_vaild     = 1'b0;
    mac_tx_data      = 8'h00;
    mac_tx_last      = 1'b0;
    gptp_ts_rv_vaild = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_in_hs) w_next = SEND;
      end
      SEND: begin
        mac_tx_vaild = 1'b1;
        mac_tx_data  = r_shreg[W-1 -: 8];
        mac_tx_last  = w_last;
        if (mac_tx_ready && w_last) w_next = REPORT;
      end
      REPORT: begin
        gptp_ts_rv_vaild = 1'b1;
        w_next           = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Ready is registered so it stays low while reset is held and rises one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready   <= 1'b0;
      r_shreg   <= '0;
      r_cnt     <= '0;
      r_ts      <= '0;
      r_rv_data <= '0;
    end else begin
      r_ready <= (w_next == IDLE);
      if (w_in_hs) begin
        r_shreg <= gptp_ts_data;
        r_cnt   <= '0;
      end else if (w_byte_acc) begin
        r_shreg <= r_shreg << 8;
        r_cnt   <= r_cnt + CW'(1);
        if (r_cnt == '0) r_ts <= w_ts_corr;
        if (w_last) r_rv_data <= (r_cnt == '0) ? w_ts_corr : r_ts;
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_ser.sv
// Randomised bench for tx_frame_ser: a queue-based model predicts the byte stream, ready and
// the timestamp pulse for two instances (latency 0 and 100 ns) and is compared every cycle.
module tb_tx_frame_ser;
  localparam int MB = 44;
  localparam int W  = MB * 8;

  logic         clk;
  logic         reset;
  logic         gptp_ts_vaild;
  logic [W-1:0] gptp_ts_data;
  logic [79:0]  rtc_time;
  logic         mac_tx_ready;

  logic         ready0, rv_vld0, mac_vld0, mac_last0;
  logic [79:0]  rv_dat0;
  logic [7:0]   mac_dat0;
  logic         ready1, rv_vld1, mac_vld1, mac_last1;
  logic [79:0]  rv_dat1;
  logic [7:0]   mac_dat1;

  tx_frame_ser #(.MSG_BYTES(MB), .EGRESS_LAT_NS(32'd0)) u_dut0 (
    .clk(clk), .reset(reset),
    .gptp_ts_vaild(gptp_ts_vaild), .gptp_ts_ready(ready0), .gptp_ts_data(gptp_ts_data),
    .gptp_ts_rv_vaild(rv_vld0), .gptp_ts_rv_data(rv_dat0), .rtc_time(rtc_time),
    .mac_tx_data(mac_dat0), .mac_tx_vaild(mac_vld0), .mac_tx_last(mac_last0),
    .mac_tx_ready(mac_tx_ready)
  );

  tx_frame_ser #(.MSG_BYTES(MB), .EGRESS_LAT_NS(32'd100)) u_dut1 (
    .clk(clk), .reset(reset),
    .gptp_ts_vaild(gptp_ts_vaild), .gptp_ts_ready(ready1), .gptp_ts_data(gptp_ts_data),
    .gptp_ts_rv_vaild(rv_vld1), .gptp_ts_rv_data(rv_dat1), .rtc_time(rtc_time),
    .mac_tx_data(mac_dat1), .mac_tx_vaild(mac_vld1), .mac_tx_last(mac_last1),
    .mac_tx_ready(mac_tx_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference timestamp: plain seconds/nanoseconds arithmetic, seconds modulo 2^48.
  function automatic logic [79:0] corr(input logic [79:0] t, input longint unsigned lat);
    longint unsigned ns_tot;
    logic [47:0]     sec;
    ns_tot = longint'(t[31:0]) + lat;
    sec    = t[79:32] + 48'(ns_tot / 64'd1000000000);
    return {sec, 32'(ns_tot % 64'd1000000000)};
  endfunction

  function automatic logic [79:0] adv(input logic [79:0] t);
    return corr(t, 8);
  endfunction

  // Model state
  logic [7:0]  byte_q[$];
  int          hs_cyc[$];
  bit          rv_due    = 0;
  bit          exp_ready = 0;
  logic [79:0] ts0 = '0, ts1 = '0, last0 = '0, last1 = '0;
  int          rv_cnt   = 0;
  int          byte_cnt = 0;

  initial begin
    bit nxt_rv;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        chk("rst_ready0", ready0, 0);   chk("rst_ready1", ready1, 0);
        chk("rst_rv_vld0", rv_vld0, 0); chk("rst_rv_vld1", rv_vld1, 0);
        chk("rst_rv_dat0", rv_dat0, 0); chk("rst_rv_dat1", rv_dat1, 0);
        chk("rst_mac_vld0", mac_vld0, 0); chk("rst_mac_vld1", mac_vld1, 0);
        chk("rst_mac_dat0", mac_dat0, 0); chk("rst_mac_last0", mac_last0, 0);
        chk("rst_mac_last1", mac_last1, 0);
        byte_q.delete();
        rv_due = 0; exp_ready = 0; last0 = '0; last1 = '0;
      end else begin
        chk("ready0", ready0, exp_ready);
        chk("ready1", ready1, exp_ready);
        chk("rv_vld0", rv_vld0, rv_due);
        chk("rv_vld1", rv_vld1, rv_due);
        if (rv_due) begin
          last0 = ts0; last1 = ts1; rv_cnt++;
        end
        chk("rv_dat0", rv_dat0, last0);
        chk("rv_dat1", rv_dat1, last1);
        chk("mac_vld0", mac_vld0, byte_q.size() != 0);
        chk("mac_vld1", mac_vld1, byte_q.size() != 0);
        if (byte_q.size() != 0) begin
          chk("mac_dat0", mac_dat0, byte_q[0]);
          chk("mac_dat1", mac_dat1, byte_q[0]);
          chk("mac_last0", mac_last0, byte_q.size() == 1);
          chk("mac_last1", mac_last1, byte_q.size() == 1);
        end
        nxt_rv = 0;
        if (byte_q.size() != 0 && mac_tx_ready) begin
          if (byte_q.size() == MB) begin
            ts0 = corr(rtc_time, 0);
            ts1 = corr(rtc_time, 100);
          end
          void'(byte_q.pop_front());
          byte_cnt++;
          if (byte_q.size() == 0) nxt_rv = 1;
        end
        if (exp_ready && gptp_ts_vaild) begin
          for (int i = 0; i < MB; i++) byte_q.push_back(gptp_ts_data[W-1-8*i -: 8]);
          hs_cyc.push_back(cyc);
        end
        exp_ready = (byte_q.size() == 0) && !nxt_rv;
        rv_due    = nxt_rv;
      end
    end
  end

  // RTC source: free-running at 8 ns/cycle unless frozen to a chosen value.
  bit          rtc_freeze = 0;
  logic [79:0] rtc_frz_val = '0;
  initial begin
    rtc_time = {48'd100, 32'd999_999_000};
    forever begin
      @(posedge clk); #1;
      if (rtc_freeze) rtc_time = rtc_frz_val;
      else            rtc_time = adv(rtc_time);
    end
  end

  // MAC backpressure: random low bursts of up to 10 cycles when enabled.
  bit bp_mode = 0;
  int bp_low  = 0;
  initial begin
    mac_tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!bp_mode) mac_tx_ready = 1'b1;
      else if (bp_low > 0) begin
        mac_tx_ready = 1'b0;
        bp_low--;
      end else if ($urandom_range(0, 2) == 0) begin
        mac_tx_ready = 1'b0;
        bp_low = $urandom_range(0, 9);
      end else mac_tx_ready = 1'b1;
    end
  end

  task automatic send_msg(input logic [W-1:0] d);
    int n = hs_cyc.size();
    @(posedge clk); #1;
    gptp_ts_vaild = 1'b1;
    gptp_ts_data  = d;
    for (int k = 0; k < 3000 && hs_cyc.size() == n; k++) @(negedge clk);
    chk("hs_timeout", hs_cyc.size(), n + 1);
    @(posedge clk); #1;
    gptp_ts_vaild = 1'b0;
  endtask

  task automatic wait_rv(input int target);
    for (int k = 0; k < 3000 && rv_cnt < target; k++) @(negedge clk);
    chk("rv_timeout", rv_cnt, target);
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rand_msg();
    logic [W-1:0] d;
    for (int j = 0; j < W / 32; j++) d[j*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic frozen_msg(input logic [79:0] t, input string nm,
                            input logic [79:0] e0, input logic [79:0] e1);
    int base = rv_cnt;
    rtc_freeze  = 1;
    rtc_frz_val = t;
    send_msg(rand_msg());
    wait_rv(base + 1);
    chk({nm, "_lat0"}, rv_dat0, e0);
    chk({nm, "_lat100"}, rv_dat1, e1);
    rtc_freeze = 0;
  endtask

  initial begin
    logic [W-1:0] d;
    int base, bc, st;
    reset = 1'b1;
    gptp_ts_vaild = 1'b0;
    gptp_ts_data  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #2;
    chk("ready_after_reset", ready0, 1);

    // T1: incrementing bytes, no backpressure, frozen RTC
    for (int i = 0; i < MB; i++) d[W-1-8*i -: 8] = 8'(i);
    bc = byte_cnt;
    rtc_freeze  = 1;
    rtc_frz_val = {48'd7, 32'd123};
    send_msg(d);
    wait_rv(1);
    chk("t1_bytes", byte_cnt - bc, MB);
    chk("t1_ts_lat0", rv_dat0, {48'd7, 32'd123});
    chk("t1_ts_lat100", rv_dat1, {48'd7, 32'd223});
    rtc_freeze = 0;

    // T3 / T4 / seconds wrap
    frozen_msg({48'd5, 32'd999_999_950}, "t3_wrap", {48'd5, 32'd999_999_950}, {48'd6, 32'd50});
    frozen_msg({48'd5, 32'd1000}, "t4_nowrap", {48'd5, 32'd1000}, {48'd5, 32'd1100});
    frozen_msg({48'hFFFF_FFFF_FFFF, 32'd999_999_999}, "sec_wrap",
               {48'hFFFF_FFFF_FFFF, 32'd999_999_999}, {48'd0, 32'd99});

    // T2: random backpressure, running RTC, random gaps
    bp_mode = 1;
    base = rv_cnt;
    for (int m = 0; m < 6; m++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      send_msg(rand_msg());
    end
    wait_rv(base + 6);
    bp_mode = 0;
    repeat (12) @(posedge clk);

    // T5: valid held across two messages
    base = rv_cnt;
    st   = hs_cyc.size();
    @(posedge clk); #1;
    gptp_ts_vaild = 1'b1;
    gptp_ts_data  = rand_msg();
    for (int k = 0; k < 3000 && hs_cyc.size() == st; k++) @(negedge clk);
    @(posedge clk); #1;
    gptp_ts_data = rand_msg();
    for (int k = 0; k < 3000 && hs_cyc.size() < st + 2; k++) @(negedge clk);
    @(posedge clk); #1;
    gptp_ts_vaild = 1'b0;
    wait_rv(base + 2);
    chk("t5_hs_count", hs_cyc.size(), st + 2);
    if (hs_cyc.size() >= st + 2) chk("t5_gap", hs_cyc[st+1] - hs_cyc[st], MB + 2);
    repeat (60) @(negedge clk);
    chk("t5_pulses", rv_cnt, base + 2);

    // T6: reset after 10 bytes
    bc = byte_cnt;
    send_msg(rand_msg());
    for (int k = 0; k < 3000 && byte_cnt < bc + 10; k++) @(negedge clk);
    chk("t6_reach_byte10", byte_cnt, bc + 10);
    base = rv_cnt;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("t6_mac_vld", mac_vld0, 0);
    chk("t6_mac_last", mac_last0, 0);
    chk("t6_mac_dat", mac_dat0, 0);
    chk("t6_ready", ready0, 0);
    chk("t6_rv_vld", rv_vld1, 0);
    chk("t6_rv_dat", rv_dat1, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (60) @(negedge clk);
    chk("t6_no_pulse", rv_cnt, base);
    bc = byte_cnt;
    send_msg(rand_msg());
    wait_rv(base + 1);
    chk("t6_next_bytes", byte_cnt - bc, MB);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
